pipeline_hazard_ctrl: RTL and testbench

- Sequences the 5-stage mips32 pipeline by generating PC/IF-ID write enables, IF-ID flush and ID-EX bubble.
- Inputs are the unit-control jump/branch outputs, the ID comparator result, the ID/EX MemRead/rt fields and data-memory busy.
- Resolves three hazard classes: load-use, control redirect and data-memory wait states.
- Also keeps stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 26 ++
 rtl/load_use_detect.sv | 14 +
 rtl/pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_FLUSH    = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_BEQ  = 2'b01;
  localparam logic [1:0] CMP_BNE  = 2'b10;
  localparam logic [1:0] CMP_JMP  = 2'b11;

  // Only beq/bne consult the comparator; CMP_JMP is covered by isJump.
  function automatic logic is_cond_branch(input logic [1:0] code);
    logic r;
    r = 1'b0;
    case (code)
      CMP_BEQ, CMP_BNE:  r = 1'b1;
      CMP_NONE, CMP_JMP: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use compare between the load in EX and the source registers in ID.
// Kept standalone so the forwarding unit can share the same compare.
module load_use_detect (
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  // $zero never carries a real dependency.
  assign load_use = mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use stalls, redirect
// flushes and data-memory wait states, plus stall/flush counters.
//
// state       | meaning
// ------------+--------------------------------------------------------
// HZ_RUN      | normal issue; hazards evaluated on the ID instruction
// HZ_FLUSH    | extra IF/ID flush cycles after a redirect (flush_cnt_q left)
// HZ_MEM_WAIT | pipeline frozen on memBusy; resumes RUN or FLUSH
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             isJump,
  input  logic [1:0]       compareCode,
  input  logic             branchTaken,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             exMemRead,
  input  logic [4:0]       exRt,
  input  logic             memBusy,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExBubble,
  output logic             memStall,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [8:0] WAIT_LIMIT = 9'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  hz_state_e        state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             resume_flush_q, resume_flush_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic             load_use;
  logic             redirect;
  logic             mem_busy_eff;
  hz_state_e        eval_state;
  logic [8:0]       wait_next;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, mem_stall;

  load_use_detect u_load_use (
    .mem_read (exMemRead),
    .ex_rt    (exRt),
    .id_rs    (idRs),
    .id_rt    (idRt),
    .load_use (load_use)
  );

  assign redirect = isJump | (is_cond_branch(compareCode) & branchTaken);

  // After a timeout the memory is treated as unresponsive: memBusy no longer
  // freezes the pipeline, and the sticky flag is the record of the fault.
  assign mem_busy_eff = memBusy & ~mem_timeout_q;

  // Next-state, counter and output decode.
  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    resume_flush_d = resume_flush_q;
    mem_timeout_d  = mem_timeout_q;
    stall_count_d  = stall_count_q;
    flush_count_d  = flush_count_q;
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    mem_stall      = 1'b0;
    wait_next      = 9'd1;
    eval_state     = state_q;

    // A released wait state behaves exactly like the state it interrupted.
    if (state_q == HZ_MEM_WAIT) begin
      eval_state = resume_flush_q ? HZ_FLUSH : HZ_RUN;
    end

    if (mem_busy_eff) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      mem_stall   = 1'b1;
      if (state_q == HZ_MEM_WAIT) begin
        wait_next = {1'b0, wait_cnt_q} + 9'd1;
      end else begin
        resume_flush_d = (state_q == HZ_FLUSH);
      end
      // wait_next counts busy cycles including this one.
      if (wait_next >= WAIT_LIMIT) begin
        mem_timeout_d = 1'b1;
        state_d       = eval_state;
        wait_cnt_d    = 8'd0;
      end else begin
        state_d    = HZ_MEM_WAIT;
        wait_cnt_d = wait_next[7:0];
      end
    end else begin
      wait_cnt_d     = 8'd0;
      resume_flush_d = 1'b0;
      case (eval_state)
        HZ_FLUSH: begin
          if_id_flush = 1'b1;
          if (flush_cnt_q <= 3'd1) begin
            state_d = HZ_RUN;
          end else begin
            state_d     = HZ_FLUSH;
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = HZ_RUN;
          if (load_use) begin
            // The redirect, if any, is re-evaluated next cycle.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (redirect) begin
            if_id_flush = 1'b1;
            if (flush_count_q != CNT_MAX) begin
              flush_count_d = flush_count_q + CNT_ONE;
            end
            if (FLUSH_CYCLES > 1) begin
              state_d     = HZ_FLUSH;
              flush_cnt_d = FLUSH_INIT;
            end
          end
        end
      endcase
    end

    if (!pc_write && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      mem_stall    = 1'b0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= HZ_RUN;
      flush_cnt_q    <= 3'd0;
      wait_cnt_q     <= 8'd0;
      resume_flush_q <= 1'b0;
      mem_timeout_q  <= 1'b0;
      stall_count_q  <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      resume_flush_q <= resume_flush_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_count_q  <= stall_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign pcWrite    = pc_write;
  assign ifIdWrite  = if_id_write;
  assign ifIdFlush  = if_id_flush;
  assign idExBubble = id_ex_bubble;
  assign memStall   = mem_stall;
  assign memTimeout = mem_timeout_q;
  assign stallCount = stall_count_q;
  assign flushCount = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed table on a FLUSH_CYCLES=3 /
// MEM_WAIT_MAX=5 instance, plus random stimulus on that instance and a
// narrow-counter FLUSH_CYCLES=1 / MEM_WAIT_MAX=2 instance, both against
// a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic       jmp;
    logic [1:0] cc;
    logic       bt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mr;
    logic [4:0] ert;
    logic       busy;
  } vin_t;

  // Expected outputs packed as {pcWrite, ifIdWrite, ifIdFlush, idExBubble, memStall}.
  typedef struct {
    vin_t       v;
    logic [4:0] o;
    logic       to;
    int         sc;
    int         fc;
  } tv_t;

  typedef struct {
    int flush_left;
    int busy_run;
    bit timed_out;
    int stall;
    int flushes;
  } mstate_t;

  logic clock = 1'b0;
  logic reset, isJump, branchTaken, exMemRead, memBusy;
  logic [1:0] compareCode;
  logic [4:0] idRs, idRt, exRt;

  logic a_pw, a_iw, a_fl, a_bb, a_ms, a_to;
  logic [15:0] a_sc, a_fc;
  logic b_pw, b_iw, b_fl, b_bb, b_ms, b_to;
  logic [2:0] b_sc, b_fc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  mstate_t ma, mb;
  tv_t tab[$];

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_WAIT_MAX(5), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .isJump(isJump), .compareCode(compareCode),
    .branchTaken(branchTaken), .idRs(idRs), .idRt(idRt), .exMemRead(exMemRead),
    .exRt(exRt), .memBusy(memBusy), .pcWrite(a_pw), .ifIdWrite(a_iw),
    .ifIdFlush(a_fl), .idExBubble(a_bb), .memStall(a_ms), .memTimeout(a_to),
    .stallCount(a_sc), .flushCount(a_fc)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_WAIT_MAX(2), .CNT_W(3)) dut_b (
    .clock(clock), .reset(reset), .isJump(isJump), .compareCode(compareCode),
    .branchTaken(branchTaken), .idRs(idRs), .idRt(idRt), .exMemRead(exMemRead),
    .exRt(exRt), .memBusy(memBusy), .pcWrite(b_pw), .ifIdWrite(b_iw),
    .ifIdFlush(b_fl), .idExBubble(b_bb), .memStall(b_ms), .memTimeout(b_to),
    .stallCount(b_sc), .flushCount(b_fc)
  );

  function automatic vin_t mk(input logic rst, input logic jmp, input logic [1:0] cc,
                              input logic bt, input logic [4:0] rs, input logic [4:0] rt,
                              input logic mr, input logic [4:0] ert, input logic busy);
    vin_t v;
    v.rst = rst; v.jmp = jmp; v.cc = cc; v.bt = bt; v.rs = rs; v.rt = rt;
    v.mr = mr; v.ert = ert; v.busy = busy;
    return v;
  endfunction

  function automatic tv_t tv(input vin_t v, input logic [4:0] o, input logic to,
                             input int sc, input int fc);
    tv_t t;
    t.v = v; t.o = o; t.to = to; t.sc = sc; t.fc = fc;
    return t;
  endfunction

  // Reference model: flush_left = forced flush cycles still owed, busy_run =
  // consecutive frozen cycles. Memory wait simply postpones whatever was owed.
  function automatic void mstep(input vin_t v, input int fcyc, input int wmax, input int cmax,
                                input mstate_t s, output mstate_t ns, output logic [4:0] o);
    bit lu, rd, busy;
    ns = s;
    if (v.rst) begin
      o = 5'b00110;
      ns = '{default: 0};
      return;
    end
    lu = v.mr && (v.ert != 0) && (v.ert == v.rs || v.ert == v.rt);
    rd = v.jmp || ((v.cc == 2'd1 || v.cc == 2'd2) && v.bt);
    busy = v.busy && !s.timed_out;
    o = 5'b11000;
    if (busy) begin
      o = 5'b00001;
      ns.busy_run = s.busy_run + 1;
      if (ns.busy_run >= wmax) begin
        ns.timed_out = 1'b1;
        ns.busy_run = 0;
      end
    end else begin
      ns.busy_run = 0;
      if (s.flush_left > 0) begin
        o = 5'b11100;
        ns.flush_left = s.flush_left - 1;
      end else if (lu) begin
        o = 5'b00010;
      end else if (rd) begin
        o = 5'b11100;
        ns.flushes = (s.flushes < cmax) ? s.flushes + 1 : cmax;
        ns.flush_left = fcyc - 1;
      end
    end
    if (o[4] == 1'b0) ns.stall = (s.stall < cmax) ? s.stall + 1 : cmax;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vin_t v);
    reset = v.rst; isJump = v.jmp; compareCode = v.cc; branchTaken = v.bt;
    idRs = v.rs; idRt = v.rt; exMemRead = v.mr; exRt = v.ert; memBusy = v.busy;
  endtask

  // Apply one cycle of inputs, check both instances against the model and,
  // when given, instance A against a table row.
  task automatic run_cycle(input vin_t v, input bit use_tab, input tv_t t);
    mstate_t na, nb;
    logic [4:0] oa, ob;
    drive(v);
    @(negedge clock);
    mstep(v, 3, 5, 65535, ma, na, oa);
    mstep(v, 1, 2, 7, mb, nb, ob);
    chk("A.outs", {27'd0, a_pw, a_iw, a_fl, a_bb, a_ms}, {27'd0, oa});
    chk("A.timeout", {31'd0, a_to}, {31'd0, ma.timed_out});
    chk("A.stallCount", {16'd0, a_sc}, ma.stall);
    chk("A.flushCount", {16'd0, a_fc}, ma.flushes);
    chk("B.outs", {27'd0, b_pw, b_iw, b_fl, b_bb, b_ms}, {27'd0, ob});
    chk("B.timeout", {31'd0, b_to}, {31'd0, mb.timed_out});
    chk("B.stallCount", {29'd0, b_sc}, mb.stall);
    chk("B.flushCount", {29'd0, b_fc}, mb.flushes);
    if (use_tab) begin
      chk("tab.outs", {27'd0, a_pw, a_iw, a_fl, a_bb, a_ms}, {27'd0, t.o});
      chk("tab.timeout", {31'd0, a_to}, {31'd0, t.to});
      chk("tab.stallCount", {16'd0, a_sc}, t.sc);
      chk("tab.flushCount", {16'd0, a_fc}, t.fc);
    end
    ma = na;
    mb = nb;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    vin_t idle, rst, jmp, busy;
    tv_t none;
    int busy_left;
    idle = mk(0, 0, 2'd0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    rst  = mk(1, 0, 2'd0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    jmp  = mk(0, 1, 2'd3, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    busy = mk(0, 0, 2'd0, 0, 5'd0, 5'd0, 0, 5'd0, 1);
    none = tv(idle, 5'b0, 0, 0, 0);

    tab.push_back(tv(rst, 5'b00110, 0, 0, 0));
    tab.push_back(tv(idle, 5'b11000, 0, 0, 0));
    tab.push_back(tv(mk(0, 0, 2'd0, 0, 5'd8, 5'd3, 1, 5'd8, 0), 5'b00010, 0, 0, 0));
    tab.push_back(tv(idle, 5'b11000, 0, 1, 0));
    tab.push_back(tv(mk(0, 0, 2'd0, 0, 5'd0, 5'd0, 1, 5'd0, 0), 5'b11000, 0, 1, 0));
    tab.push_back(tv(jmp, 5'b11100, 0, 1, 0));
    tab.push_back(tv(jmp, 5'b11100, 0, 1, 1));
    tab.push_back(tv(idle, 5'b11100, 0, 1, 1));
    tab.push_back(tv(idle, 5'b11000, 0, 1, 1));
    tab.push_back(tv(mk(0, 0, 2'd1, 0, 5'd1, 5'd2, 0, 5'd0, 0), 5'b11000, 0, 1, 1));
    tab.push_back(tv(mk(0, 0, 2'd1, 1, 5'd1, 5'd2, 0, 5'd0, 0), 5'b11100, 0, 1, 1));
    tab.push_back(tv(busy, 5'b00001, 0, 1, 2));
    tab.push_back(tv(busy, 5'b00001, 0, 2, 2));
    tab.push_back(tv(busy, 5'b00001, 0, 3, 2));
    tab.push_back(tv(busy, 5'b00001, 0, 4, 2));
    tab.push_back(tv(idle, 5'b11100, 0, 5, 2));
    tab.push_back(tv(idle, 5'b11100, 0, 5, 2));
    tab.push_back(tv(idle, 5'b11000, 0, 5, 2));
    tab.push_back(tv(mk(0, 0, 2'd3, 1, 5'd0, 5'd0, 0, 5'd0, 0), 5'b11000, 0, 5, 2));
    tab.push_back(tv(mk(0, 1, 2'd3, 0, 5'd4, 5'd9, 1, 5'd9, 0), 5'b00010, 0, 5, 2));
    tab.push_back(tv(jmp, 5'b11100, 0, 6, 2));
    tab.push_back(tv(rst, 5'b00110, 0, 6, 3));
    tab.push_back(tv(idle, 5'b11000, 0, 0, 0));
    tab.push_back(tv(mk(0, 0, 2'd0, 0, 5'd7, 5'd0, 1, 5'd7, 1), 5'b00001, 0, 0, 0));
    tab.push_back(tv(busy, 5'b00001, 0, 1, 0));
    tab.push_back(tv(busy, 5'b00001, 0, 2, 0));
    tab.push_back(tv(busy, 5'b00001, 0, 3, 0));
    tab.push_back(tv(busy, 5'b00001, 0, 4, 0));
    for (int i = 0; i < 5; i++) tab.push_back(tv(busy, 5'b11000, 1, 5, 0));
    tab.push_back(tv(idle, 5'b11000, 1, 5, 0));
    tab.push_back(tv(rst, 5'b00110, 1, 5, 0));
    tab.push_back(tv(idle, 5'b11000, 0, 0, 0));
    tab.push_back(tv(mk(0, 0, 2'd2, 1, 5'd0, 5'd0, 0, 5'd0, 0), 5'b11100, 0, 0, 0));
    tab.push_back(tv(idle, 5'b11100, 0, 0, 1));
    tab.push_back(tv(idle, 5'b11100, 0, 0, 1));
    tab.push_back(tv(idle, 5'b11000, 0, 0, 1));

    // Two reset cycles bring both instances to a known state.
    drive(rst);
    repeat (2) @(posedge clock);
    #1;
    ma = '{default: 0};
    mb = '{default: 0};

    foreach (tab[i]) run_cycle(tab[i].v, 1'b1, tab[i]);

    busy_left = 0;
    for (int n = 0; n < 3000; n++) begin
      vin_t v;
      v.rst  = ($urandom_range(0, 79) == 0);
      v.jmp  = ($urandom_range(0, 5) == 0);
      v.cc   = 2'($urandom_range(0, 3));
      v.bt   = 1'($urandom_range(0, 1));
      v.rs   = 5'($urandom_range(0, 3));
      v.rt   = 5'($urandom_range(0, 3));
      v.mr   = ($urandom_range(0, 2) == 0);
      v.ert  = 5'($urandom_range(0, 3));
      if (busy_left == 0 && $urandom_range(0, 7) == 0) busy_left = $urandom_range(1, 8);
      v.busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      run_cycle(v, 1'b0, none);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
